// File: rtl/miriscv_imm_pipe_if.sv
// Valid/ready bundle for the immediate extraction pipe.
// slave = pipe view, master = fetch/decode side view.
interface miriscv_imm_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_instr_i;
    logic [TAG_W-1:0] in_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  out_imm_o;
    logic [2:0]       out_kind_o;
    logic             out_illegal_o;
    logic [TAG_W-1:0] out_tag_o;

    modport slave (
        input  in_valid_i, in_instr_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_imm_o, out_kind_o,
        output out_illegal_o, out_tag_o
    );

    modport master (
        output in_valid_i, in_instr_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_imm_o, out_kind_o,
        input  out_illegal_o, out_tag_o
    );
endinterface

// File: rtl/miriscv_imm_pipe.sv
// Immediate extraction stage (1 or 2 register stages, valid/ready, flush).
// Define MIRISCV_IMM_RVC_EN to decode compressed quadrant 01 immediates.
module miriscv_imm_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    miriscv_imm_pipe_if.slave io
);
    localparam logic [2:0] K_NONE  = 3'd0;
    localparam logic [2:0] K_I     = 3'd1;
    localparam logic [2:0] K_S     = 3'd2;
    localparam logic [2:0] K_B     = 3'd3;
    localparam logic [2:0] K_U     = 3'd4;
    localparam logic [2:0] K_J     = 3'd5;
    localparam logic [2:0] K_ZIMM  = 3'd6;
    localparam logic [2:0] K_SHAMT = 3'd7;

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [31:0]     w_i;
    logic [4:0]      w_op;
    logic [2:0]      w_f3;
    logic            w_sh;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_kind;
    logic            w_ill;

    assign w_i  = io.in_instr_i;
    assign w_op = w_i[6:2];
    assign w_f3 = w_i[14:12];
    assign w_sh = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    always_comb begin
        w_imm  = '0;
        w_kind = K_NONE;
        w_ill  = 1'b0;
        if (w_i[1:0] == 2'b11) begin
            case (w_op)
                5'b00100: begin
                    if (w_sh) begin
                        w_kind = K_SHAMT;
                        if (XLEN == 64) begin
                            w_imm[5:0] = w_i[25:20];
                        end else begin
                            w_imm[4:0] = w_i[24:20];
                            w_ill      = w_i[25];
                        end
                    end else begin
                        w_kind = K_I;
                        w_imm  = sx({{20{w_i[31]}}, w_i[31:20]});
                    end
                end
                5'b00110: begin
                    if (XLEN == 64) begin
                        if (w_sh) begin
                            w_kind     = K_SHAMT;
                            w_imm[4:0] = w_i[24:20];
                            w_ill      = w_i[25];
                        end else begin
                            w_kind = K_I;
                            w_imm  = sx({{20{w_i[31]}}, w_i[31:20]});
                        end
                    end
                end
                5'b00000, 5'b11001: begin
                    w_kind = K_I;
                    w_imm  = sx({{20{w_i[31]}}, w_i[31:20]});
                end
                5'b01000: begin
                    w_kind = K_S;
                    w_imm  = sx({{20{w_i[31]}}, w_i[31:25], w_i[11:7]});
                end
                5'b11000: begin
                    w_kind = K_B;
                    w_imm  = sx({{19{w_i[31]}}, w_i[31], w_i[7],
                                 w_i[30:25], w_i[11:8], 1'b0});
                end
                5'b01101, 5'b00101: begin
                    w_kind = K_U;
                    w_imm  = sx({w_i[31:12], 12'b0});
                end
                5'b11011: begin
                    w_kind = K_J;
                    w_imm  = sx({{11{w_i[31]}}, w_i[31], w_i[19:12],
                                 w_i[20], w_i[30:21], 1'b0});
                end
                5'b11100: begin
                    if (w_f3 != 3'b000) begin
                        w_kind     = K_ZIMM;
                        w_imm[4:0] = w_i[19:15];
                    end
                end
                default: ;
            endcase
        end else begin
`ifdef MIRISCV_IMM_RVC_EN
            if (w_i[1:0] == 2'b01) begin
                case (w_i[15:13])
                    3'b000, 3'b010: begin
                        w_kind = K_I;
                        w_imm  = sx({{26{w_i[12]}}, w_i[12], w_i[6:2]});
                    end
                    3'b001, 3'b101: begin
                        if (XLEN == 64 && w_i[15:13] == 3'b001) begin
                            w_kind = K_I;
                            w_imm  = sx({{26{w_i[12]}}, w_i[12], w_i[6:2]});
                        end else begin
                            w_kind = K_J;
                            w_imm  = sx({{20{w_i[12]}}, w_i[12], w_i[8],
                                         w_i[10:9], w_i[6], w_i[7], w_i[2],
                                         w_i[11], w_i[5:3], 1'b0});
                        end
                    end
                    3'b110, 3'b111: begin
                        w_kind = K_B;
                        w_imm  = sx({{23{w_i[12]}}, w_i[12], w_i[6:5],
                                     w_i[2], w_i[11:10], w_i[4:3], 1'b0});
                    end
                    3'b011: begin
                        // rd==x2 is C.ADDI16SP, which carries no U immediate
                        if (w_i[11:7] != 5'd2) begin
                            w_kind = K_U;
                            w_imm  = sx({{14{w_i[12]}}, w_i[12], w_i[6:2],
                                         12'b0});
                            w_ill  = ({w_i[12], w_i[6:2]} == 6'd0);
                        end
                    end
                    default: ;
                endcase
            end
`else
            w_ill = 1'b1;
`endif
        end
    end

    logic             r_v1;
    logic [XLEN-1:0]  r_imm1;
    logic [2:0]       r_kind1;
    logic             r_ill1;
    logic [TAG_W-1:0] r_tag1;
    logic             w_rdy1;
    logic             w_rdy_nxt;

    assign w_rdy1        = !r_v1 || w_rdy_nxt;
    assign io.in_ready_o = w_rdy1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1    <= 1'b0;
            r_imm1  <= '0;
            r_kind1 <= '0;
            r_ill1  <= 1'b0;
            r_tag1  <= '0;
        end else begin
            if (flush_i)
                r_v1 <= 1'b0;
            else if (w_rdy1)
                r_v1 <= io.in_valid_i;
            if (!flush_i && w_rdy1 && io.in_valid_i) begin
                r_imm1  <= w_imm;
                r_kind1 <= w_kind;
                r_ill1  <= w_ill;
                r_tag1  <= io.in_tag_i;
            end
        end
    end

    generate
        if (STAGES == 2) begin : g_s2
            logic             r_v2;
            logic [XLEN-1:0]  r_imm2;
            logic [2:0]       r_kind2;
            logic             r_ill2;
            logic [TAG_W-1:0] r_tag2;

            assign w_rdy_nxt = !r_v2 || io.out_ready_i;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_v2    <= 1'b0;
                    r_imm2  <= '0;
                    r_kind2 <= '0;
                    r_ill2  <= 1'b0;
                    r_tag2  <= '0;
                end else begin
                    if (flush_i)
                        r_v2 <= 1'b0;
                    else if (w_rdy_nxt)
                        r_v2 <= r_v1;
                    if (!flush_i && w_rdy_nxt && r_v1) begin
                        r_imm2  <= r_imm1;
                        r_kind2 <= r_kind1;
                        r_ill2  <= r_ill1;
                        r_tag2  <= r_tag1;
                    end
                end
            end

            assign io.out_valid_o   = r_v2;
            assign io.out_imm_o     = r_imm2;
            assign io.out_kind_o    = r_kind2;
            assign io.out_illegal_o = r_ill2;
            assign io.out_tag_o     = r_tag2;
        end else begin : g_s1
            assign w_rdy_nxt        = io.out_ready_i;
            assign io.out_valid_o   = r_v1;
            assign io.out_imm_o     = r_imm1;
            assign io.out_kind_o    = r_kind1;
            assign io.out_illegal_o = r_ill1;
            assign io.out_tag_o     = r_tag1;
        end
    endgenerate
endmodule

// File: doc/miriscv_imm_pipe.md
Name: miriscv_imm_pipe

Overview:
- Pipelined, XLEN-generic immediate extraction stage between fetch and decode.
- Accepts instruction words over a valid/ready handshake and extracts the immediate, sign- or zero-extended to XLEN.
- Also produces an immediate-kind code and an illegal-immediate flag.
- Carries a sideband tag (PC or ROB id) through 1 or 2 register stages with full throughput, back-pressure and flush.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- STAGES, 1, number of register stages; legal values are 1 and 2.
- TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous kill of all in-flight entries
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  stage can accept input
- in_instr_i  in  32  instruction word; low 16 bits only when compressed
- in_tag_i  in  TAG_W  sideband tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- out_imm_o  out  XLEN  extended immediate
- out_kind_o  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 ZIMM, 7 SHAMT
- out_illegal_o  out  1  immediate field is illegal for this XLEN/config
- out_tag_o  out  TAG_W  tag of the result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: all stage valid bits are 0, and out_imm_o, out_kind_o, out_illegal_o and out_tag_o are 0. in_ready_o is 1 after reset.
- Handshake, per stage: a transfer occurs when valid&&ready.
  - stage_ready = !stage_valid || next_ready.
  - in_ready_o equals the first stage's stage_ready (combinational from out_ready_i; no skid).
  - Data holds stable while out_valid_o=1 and out_ready_i=0.
- Latency and throughput: STAGES cycles from input to output; 1 result per cycle with out_ready_i held high.
  - Decode logic sits before stage 1; stage 2, when present, is a pure register.
- Flush:
  - flush_i clears every valid bit on the next edge.
  - An input presented in the same cycle is dropped.
  - Data registers need not clear.
  - flush_i has priority over simultaneous accept.
- Decode, keyed on in_instr_i[6:2] when in_instr_i[1:0]==2'b11. "sx" = sign-extend from instr[31] to XLEN.
  - OPIMM 00100:
    - funct3 001/101: SHAMT, zero-extended. XLEN=64 uses instr[25:20]; XLEN=32 uses instr[24:20], and instr[25]=1 sets illegal.
    - Otherwise kind I.
  - OPIMM32 00110: legal only when XLEN=64; funct3 001/101 give SHAMT from instr[24:20], and instr[25]=1 sets illegal. Other funct3 give I. When XLEN=32 the result is NONE, not illegal.
  - LOAD 00000 and JALR 11001: I, sx{instr[31:20]}.
  - STORE 01000: S, sx{instr[31:25],instr[11:7]}.
  - BRANCH 11000: B, sx{instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - LUI 01101 and AUIPC 00101: U, sx{instr[31:12],12'b0}. For XLEN=64 bits 63:32 replicate instr[31].
  - JAL 11011: J, sx{instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - SYSTEM 11100: funct3!=000 gives ZIMM, zero-extended instr[19:15]. funct3==000 gives NONE.
  - All other opcodes: NONE, imm 0, illegal 0.
- Compressed input (in_instr_i[1:0]!=2'b11) when the optional feature is absent: NONE, imm 0, illegal 1.
- Tag: captured with the instruction and propagated unchanged.

Optional Feature:
- Macro: MIRISCV_IMM_RVC_EN.
- Defined: compressed quadrant 01 is decoded, using the 16-bit word c=in_instr_i[15:0] with funct3=c[15:13]. "sx" here sign-extends from the field's top bit.
  - 000 C.ADDI and 010 C.LI: I, sx{c[12],c[6:2]}.
  - 001: C.JAL when XLEN=32, C.ADDIW when XLEN=64.
    - C.JAL: J, sx{c[12],c[8],c[10:9],c[6],c[7],c[2],c[11],c[5:3],0}.
    - C.ADDIW: I, as C.ADDI.
  - 101 C.J: J, same layout as C.JAL.
  - 110/111 C.BEQZ/C.BNEZ: B, sx{c[12],c[6:5],c[2],c[11:10],c[4:3],0}.
  - 011 with c[11:7]!=2: U, sx{c[12],c[6:2],12'b0}. If that 6-bit field is 0, set illegal.
  - Any other compressed encoding: NONE, illegal 0.
- Undefined: compressed input always gives illegal 1, as stated above.

Test Plan:
- STAGES=1, XLEN=32: in 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, imm 0xFFFFFFFF, kind I, illegal 0.
- XLEN=64: in 0x800000B7 (lui x1,0x80000) -> imm 0xFFFFFFFF80000000, kind U. In 0x03F09093 (slli x1,x1,63) -> SHAMT, imm 63, illegal 0. The same slli with XLEN=32 -> illegal 1.
- STAGES=2 back-pressure: stream 4 branches 0xFE000EE3 (beq -4), out_ready=0 for 3 cycles mid-stream -> in_ready deasserts once both stages are full; all 4 results are imm 0xFFFFFFFC, kind B, in order with tags intact; no loss or duplication.
- Flush: flush_i asserted with both stages valid and a new input presented -> next cycle out_valid=0, and the input is not delivered.
- Reset asserted mid-stream asynchronously -> out_valid_o=0 and outputs 0 immediately, without waiting for a clock edge; in_ready_o=1.
- With MIRISCV_IMM_RVC_EN: 0x1FFD (c.addi x31,-1) -> I, imm -1. 0xBFFD (c.j -2) -> J, imm -2. Without the macro, the same words give illegal 1.
